// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - 16-bit add/subtract computed one nibble per cycle on a shared 4-bit adder
//
// Optional feature macro: NIBBLE_ADD_SEQ_SUB_EN (enables subtract mode via SUB)
//
// full_adder_4bit ports:
//   a, b      4-bit operands
//   cin       carry-in
//   s         4-bit sum
//   cout      carry-out
//
// nibble_add_seq ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   in_valid  operand request
//   in_ready  operands can be accepted (IDLE)
//   A, B      16-bit operands
//   Cin       carry-in (add mode)
//   SUB       subtract request (used only with NIBBLE_ADD_SEQ_SUB_EN)
//   out_valid result available (DONE)
//   out_ready consumer takes the result
//   S         16-bit sum
//   Cout      carry-out of bit 15 (1 = no borrow when subtracting)
//   OVF       two's-complement overflow

module full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] w_total;

  assign w_total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign s       = w_total[3:0];
  assign cout    = w_total[4];

endmodule

module nibble_add_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  input  logic        SUB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] S,
  output logic        Cout,
  output logic        OVF
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [15:0] r_a;
  logic [15:0] r_b;      // B or ~B, fixed at acceptance
  logic        r_carry;
  logic [15:0] r_s;
  logic        r_cout;
  logic        r_ovf;
  logic        r_in_ready;
  logic        r_out_valid;

  logic        w_sub;
  logic [15:0] w_bop;
  logic        w_cin;
  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic [3:0]  w_sum;
  logic        w_cout;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  assign w_sub = SUB;
`else
  // SUB stays on the port list so both builds share one interface.
  assign w_sub = SUB & 1'b0;
`endif

  // Subtract is A + ~B + 1; the caller's Cin is ignored in that mode.
  assign w_bop = w_sub ? ~B : B;
  assign w_cin = w_sub ? 1'b1 : Cin;

  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

  full_adder_4bit u_fa (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_a         <= 16'h0000;
      r_b         <= 16'h0000;
      r_carry     <= 1'b0;
      r_s         <= 16'h0000;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_in_ready && in_valid) begin
            r_a        <= A;
            r_b        <= w_bop;
            r_carry    <= w_cin;
            r_idx      <= 2'd0;
            r_s        <= 16'h0000;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end else begin
            // First cycle out of reset raises in_ready here.
            r_in_ready <= 1'b1;
          end
        end
        CALC: begin
          r_s[{r_idx, 2'b00} +: 4] <= w_sum;
          r_carry <= w_cout;
          r_idx   <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_cout      <= w_cout;
            // Overflow uses the freshly computed top bit (w_sum[3]).
            r_ovf       <= (r_a[15] == r_b[15]) && (w_sum[3] != r_a[15]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign S         = r_s;
  assign Cout      = r_cout;
  assign OVF       = r_ovf;

endmodule
